// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative WIDTH x WIDTH multiply / divide with architectural HI/LO registers.
// A fixed sequence of one launch edge, WIDTH step edges and one fix-up edge; busy stalls the
// pipeline meanwhile. Define MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU
// run the same sequence but only set div0 as an unsupported-op flag.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;    // upper: partial product / remainder, lower: a / quotient
    logic [WIDTH-1:0]   bm_q, bm_d;      // magnitude of b
    logic               psign_q, psign_d; // a^b sign, shared by product and quotient
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, div0_q, div0_d;
    logic               launch, step, fix;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod_fix;
`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]   a_q, a_d;        // original dividend bit pattern for the divide-by-zero result
    logic               rsign_q, rsign_d;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub, rem_new, quo_fix, rem_fix;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-decoded controls
    always_comb begin
        busy   = (state_q != StIdle);
        launch = (state_q == StIdle) && start;
        step   = (state_q == StRun);
        fix    = (state_q == StFix);
    end

    // Arithmetic: operand magnitudes, one iteration step, final sign correction
    always_comb begin
        a_mag    = (!op[0] && a[WIDTH-1]) ? -a : a;
        b_mag    = (!op[0] && b[WIDTH-1]) ? -b : b;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bm_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        prod_fix = (!op_q[0] && psign_q) ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (rem_sh >= {1'b0, bm_q});
        // Only used when div_ge, where the true difference fits in WIDTH bits
        rem_sub  = rem_sh[WIDTH-1:0] - bm_q;
        rem_new  = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
        div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};
        quo_fix  = (!op_q[0] && psign_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = (!op_q[0] && rsign_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
    end

    // Datapath and architectural register next-state
    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        bm_d    = bm_q;
        psign_d = psign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = div0_q;
`ifdef MULDIV_DIV_EN
        a_d     = a_q;
        rsign_d = rsign_q;
`endif
        if (launch) begin
            op_d    = op;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            bm_d    = b_mag;
            psign_d = a[WIDTH-1] ^ b[WIDTH-1];
            cnt_d   = '0;
`ifdef MULDIV_DIV_EN
            a_d     = a;
            rsign_d = a[WIDTH-1];
`endif
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            if (!op_q[1]) begin
                acc_d = mul_next;
            end
`ifdef MULDIV_DIV_EN
            else begin
                acc_d = div_next;
            end
`endif
        end else if (fix) begin
            done_d = 1'b1;
            if (!op_q[1]) begin
                {hi_d, lo_d} = prod_fix;
            end else begin
`ifdef MULDIV_DIV_EN
                if (bm_q == '0) begin
                    hi_d   = a_q;
                    lo_d   = '1;
                    div0_d = 1'b1;
                end else begin
                    hi_d   = rem_fix;
                    lo_d   = quo_fix;
                    div0_d = 1'b0;
                end
`else
                div0_d = 1'b1;
`endif
            end
        end
        // MTHI/MTLO only land while idle; a launch in the same cycle is overwritten at FIX
        if (state_q == StIdle) begin
            if (hi_we) hi_d = wd;
            if (lo_we) lo_d = wd;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            bm_q    <= '0;
            psign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            a_q     <= '0;
            rsign_q <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            bm_q    <= bm_d;
            psign_q <= psign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
`ifdef MULDIV_DIV_EN
            a_q     <= a_d;
            rsign_q <= rsign_d;
`endif
        end
    end

    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit. Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

    logic        clk, rst_n, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

`ifdef MULDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input logic [31:0] eh, input logic [31:0] el,
                              input logic ed);
        check_eq({tag, "_hi"}, hi, eh);
        check_eq({tag, "_lo"}, lo, el);
        check_eq({tag, "_div0"}, div0, ed);
        exp_hi = eh;
        exp_lo = el;
    endtask

    // Launch one operation; optionally poke start and MTHI while it runs.
    task automatic run_op(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input bit poke);
        int busy_cnt = 0;
        int hold_bad = 0;
        op = o; a = ia; b = ib; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && busy; i++) begin
            busy_cnt++;
            if (hi !== exp_hi || lo !== exp_lo || done) hold_bad++;
            if (poke && i == 5) begin
                start = 1'b1; op = 2'b01; a = 32'h100; b = 32'h100;
                hi_we = 1'b1; wd = 32'h1234;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            tick();
        end
        start = 1'b0; hi_we = 1'b0;
        check_eq("busy_cycles", busy_cnt, 33);
        check_eq("hold_during_run", hold_bad, 0);
        check_eq("done_pulse", done, 1'b1);
        tick();
        check_eq("done_single", done, 1'b0);
        check_eq("idle_after", busy, 1'b0);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wd = '0;
        #2;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        expect_res("rst", 32'h0, 32'h0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expect_res("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        expect_res("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

        hi_we = 1'b1; wd = 32'h1111_2222; tick(); hi_we = 1'b0;
        lo_we = 1'b1; wd = 32'h3333_4444; tick(); lo_we = 1'b0;
        expect_res("mthi_mtlo", 32'h1111_2222, 32'h3333_4444, 1'b0);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        if (DivEn) expect_res("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        else       expect_res("div_neg", exp_hi, exp_lo, 1'b1);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        if (DivEn) expect_res("div_ovf", 32'h0, 32'h8000_0000, 1'b0);
        else       expect_res("div_ovf", exp_hi, exp_lo, 1'b1);

        run_op(2'b11, 32'd100, 32'd0, 1'b0);
        if (DivEn) expect_res("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        else       expect_res("divu_zero", exp_hi, exp_lo, 1'b1);

        // Interfering start and MTHI while busy; div0 must survive a multiply
        run_op(2'b01, 32'd7, 32'd6, 1'b1);
        expect_res("multu_poke", 32'h0, 32'd42, 1'b1);

        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        if (DivEn) expect_res("divu_clr", 32'd2, 32'd14, 1'b0);
        else       expect_res("divu_clr", exp_hi, exp_lo, 1'b1);

        // Asynchronous reset partway through a multiply
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check_eq("busy_before_abort", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        expect_res("abort", 32'h0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) done_seen++;
            tick();
        end
        check_eq("no_done_after_abort", done_seen, 0);

        run_op(2'b01, 32'd3, 32'd4, 1'b0);
        expect_res("multu_after_rst", 32'h0, 32'd12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
